alu_cmd_issue: RTL and testbench

Upstream issue stage for the 16-bit ALU/barrel-shifter datapath. It buffers operation commands (two operands, select, shift magnitude) in a small FIFO and drives them into the purely combinational ALU as registered inputs. It captures the ALU result one cycle later and presents it downstream with a valid/ready handshake. The block gives the combinational ALU a clocked, flow-controlled front end.

---
 rtl/alu_cmd_issue.sv | 140 ++++++++++++++
 tb/tb_alu_cmd_issue.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issue.sv
// Clocked issue stage for the combinational 16-bit ALU: command FIFO, registered ALU drive,
// captured result with valid/ready handoff.
module alu_cmd_issue #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SEL_W = 3,
   parameter int unsigned SH_W  = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [WIDTH-1:0]        cmd_i0,
   input  logic [WIDTH-1:0]        cmd_i1,
   input  logic [SEL_W-1:0]        cmd_sel,
   input  logic [SH_W-1:0]         cmd_shift,
   output logic [WIDTH-1:0]        alu_i0,
   output logic [WIDTH-1:0]        alu_i1,
   output logic [SEL_W-1:0]        alu_select,
   output logic [SH_W-1:0]         alu_shift_mag,
   input  logic [WIDTH-1:0]        alu_o,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [WIDTH-1:0]        res_data,
   output logic [SEL_W-1:0]        res_sel,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    busy
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DepthC = CW'(DEPTH);

   typedef struct packed {
      logic [WIDTH-1:0] i0;
      logic [WIDTH-1:0] i1;
      logic [SEL_W-1:0] sel;
      logic [SH_W-1:0]  shift;
   } cmd_t;

   typedef enum logic [1:0] {StIdle, StIssue, StCapture, StHold} state_e;

   state_e            state_q, state_d;
   cmd_t              mem_q [DEPTH];
   cmd_t              issue_q;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [WIDTH-1:0]  res_data_q;
   logic [SEL_W-1:0]  res_sel_q;
   logic              push, pop, capture;
   cmd_t              cmd_in;

   assign cmd_ready = (count_q < DepthC);
   assign push      = cmd_valid && cmd_ready;
   assign cmd_in    = '{i0: cmd_i0, i1: cmd_i1, sel: cmd_sel, shift: cmd_shift};

   // Pops only look at the registered count, so a command never bypasses the FIFO.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      capture = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: state_d = StCapture;
         StCapture: begin
            capture = 1'b1;
            state_d = StHold;
         end
         StHold: begin
            if (res_ready) begin
               if (count_q != '0) begin
                  pop     = 1'b1;
                  state_d = StIssue;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         issue_q    <= '0;
         res_data_q <= '0;
         res_sel_q  <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (pop) begin
            issue_q <= mem_q[rd_ptr_q];
         end
         if (capture) begin
            res_data_q <= alu_o;
            res_sel_q  <= issue_q.sel;
         end
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= cmd_in;
      end
   end

   assign alu_i0        = issue_q.i0;
   assign alu_i1        = issue_q.i1;
   assign alu_select    = issue_q.sel;
   assign alu_shift_mag = issue_q.shift;
   assign res_valid     = (state_q == StHold);
   assign res_data      = res_data_q;
   assign res_sel       = res_sel_q;
   assign count         = count_q;
   assign busy          = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Bench for alu_cmd_issue: XOR ALU stub, directed latency vectors, corner-case sequences and a
// queue scoreboard fed by randomized traffic.
module tb_alu_cmd_issue;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned SEL_W = 3;
   localparam int unsigned SH_W  = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic              clk;
   logic              rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [WIDTH-1:0]  cmd_i0, cmd_i1;
   logic [SEL_W-1:0]  cmd_sel;
   logic [SH_W-1:0]   cmd_shift;
   logic [WIDTH-1:0]  alu_i0, alu_i1, alu_o;
   logic [SEL_W-1:0]  alu_select;
   logic [SH_W-1:0]   alu_shift_mag;
   logic              res_valid, res_ready;
   logic [WIDTH-1:0]  res_data;
   logic [SEL_W-1:0]  res_sel;
   logic [CW-1:0]     count;
   logic              busy;

   alu_cmd_issue #(.WIDTH(WIDTH), .SEL_W(SEL_W), .SH_W(SH_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_i0(cmd_i0), .cmd_i1(cmd_i1), .cmd_sel(cmd_sel), .cmd_shift(cmd_shift),
      .alu_i0(alu_i0), .alu_i1(alu_i1), .alu_select(alu_select), .alu_shift_mag(alu_shift_mag),
      .alu_o(alu_o),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_sel(res_sel),
      .count(count), .busy(busy)
   );

   assign alu_o = alu_i0 ^ alu_i1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_res   = 0;
   int cyc     = 0;
   int last_hs = -1;
   bit thr_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: every accepted command must come back once, in order, as i0 ^ i1.
   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SEL_W-1:0] sel;
   } res_t;
   res_t exp_q[$];
   res_t e;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         check("occupancy_bound", (count <= CW'(DEPTH)), 1);
         check("ready_vs_count", cmd_ready, (count < CW'(DEPTH)));
         if (cmd_valid && cmd_ready) exp_q.push_back('{cmd_i0 ^ cmd_i1, cmd_sel});
         if (res_valid && res_ready) begin
            n_res++;
            if (thr_en && last_hs >= 0) check("thr_gap", cyc - last_hs, 3);
            last_hs = cyc;
            if (exp_q.size() == 0) begin
               check("sb_unexpected_result", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("sb_data", res_data, e.data);
               check("sb_sel", res_sel, e.sel);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [SEL_W-1:0] s, input logic [SH_W-1:0] sh);
      cmd_valid = 1'b1;
      cmd_i0    = a;
      cmd_i1    = b;
      cmd_sel   = s;
      cmd_shift = sh;
   endtask

   task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [SEL_W-1:0] s, input logic [SH_W-1:0] sh);
      int budget = 200;
      drive(a, b, s, sh);
      while (!cmd_ready && budget > 0) begin
         tick();
         budget--;
      end
      if (!cmd_ready) check("push_timeout", 0, 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int budget = 300;
      res_ready = 1'b1;
      while ((busy || exp_q.size() != 0) && budget > 0) begin
         tick();
         budget--;
      end
      check(name, busy, 0);
      check({name, "_queue"}, exp_q.size(), 0);
   endtask

   typedef struct {
      logic [WIDTH-1:0] i0;
      logic [WIDTH-1:0] i1;
      logic [SEL_W-1:0] sel;
      logic [SH_W-1:0]  sh;
      logic [WIDTH-1:0] exp;
   } vec_t;
   vec_t vecs[4];

   bit   push_done;
   int   n0;

   initial begin
      // 64 ^ 320 = 256, 500 ^ 1000 = 540
      vecs[0] = '{16'd64,     16'd320,    3'd0, 4'd2,  16'd256};
      vecs[1] = '{16'd500,    16'd1000,   3'd5, 4'd15, 16'd540};
      vecs[2] = '{16'hFFFF,   16'h0F0F,   3'd7, 4'd9,  16'hF0F0};
      vecs[3] = '{16'hA5A5,   16'hA5A5,   3'd3, 4'd0,  16'h0000};

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_i0    = '0;
      cmd_i1    = '0;
      cmd_sel   = '0;
      cmd_shift = '0;
      res_ready = 1'b1;
      tick();
      check("rst_count", count, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      check("rst_alu_i0", alu_i0, 0);
      check("rst_busy", busy, 0);
      @(posedge clk);
      #3 rst = 1'b0;
      tick();
      check("rst_cmd_ready", cmd_ready, 1);

      // Single-command latency, one vector at a time.
      foreach (vecs[i]) begin
         drive(vecs[i].i0, vecs[i].i1, vecs[i].sel, vecs[i].sh);
         check("v_ready", cmd_ready, 1);
         tick();
         cmd_valid = 1'b0;
         check("v_count_push", count, 1);
         check("v_busy", busy, 1);
         tick();
         check("v_alu_i0", alu_i0, vecs[i].i0);
         check("v_alu_i1", alu_i1, vecs[i].i1);
         check("v_alu_sel", alu_select, vecs[i].sel);
         check("v_alu_sh", alu_shift_mag, vecs[i].sh);
         check("v_count_pop", count, 0);
         check("v_valid_issue", res_valid, 0);
         tick();
         check("v_valid_capture", res_valid, 0);
         tick();
         check("v_res_valid", res_valid, 1);
         check("v_res_data", res_data, vecs[i].exp);
         check("v_res_sel", res_sel, vecs[i].sel);
         tick();
         check("v_done_valid", res_valid, 0);
         check("v_done_busy", busy, 0);
      end

      // Fill under backpressure; the sixth command must be refused.
      res_ready = 1'b0;
      n0 = n_res;
      for (int k = 0; k < 5; k++) push(WIDTH'(100 + k), WIDTH'(7 * k), SEL_W'(k), SH_W'(k));
      check("fill_count", count, DEPTH);
      check("fill_ready", cmd_ready, 0);
      check("fill_valid", res_valid, 1);
      check("fill_res_sel", res_sel, 0);
      drive(16'h7777, 16'h1111, 3'd5, 4'd5);
      tick();
      tick();
      check("fill_ignored_count", count, DEPTH);
      check("fill_hold_sel", res_sel, 0);
      cmd_valid = 1'b0;
      drain("fill_drain");
      check("fill_results", n_res - n0, 5);

      // HOLD stability over ten stalled cycles.
      res_ready = 1'b0;
      push(16'd500, 16'd1000, 3'd6, 4'd11);
      for (int k = 0; k < 20 && !res_valid; k++) tick();
      check("hold_reach", res_valid, 1);
      for (int k = 0; k < 10; k++) begin
         tick();
         check("hold_valid", res_valid, 1);
         check("hold_data", res_data, 540);
         check("hold_sel", res_sel, 6);
         check("hold_alu_i0", alu_i0, 500);
         check("hold_alu_i1", alu_i1, 1000);
         check("hold_alu_sel", alu_select, 6);
         check("hold_alu_sh", alu_shift_mag, 11);
      end
      res_ready = 1'b1;
      tick();
      check("hold_release", res_valid, 0);
      drain("hold_drain");

      // Order and throughput: one result every three cycles once the pipe is primed.
      n0      = n_res;
      last_hs = -1;
      thr_en  = 1'b1;
      for (int k = 1; k <= 8; k++) push(WIDTH'(k), '0, SEL_W'(k), '0);
      drain("thr_drain");
      thr_en = 1'b0;
      check("thr_results", n_res - n0, 8);

      // Reset while in CAPTURE with two commands queued.
      n0 = n_res;
      push(16'd11, 16'd22, 3'd1, 4'd1);
      push(16'd33, 16'd44, 3'd2, 4'd2);
      push(16'd55, 16'd66, 3'd3, 4'd3);
      check("mid_count", count, 2);
      check("mid_valid", res_valid, 0);
      check("mid_busy", busy, 1);
      #2 rst = 1'b1;
      exp_q.delete();
      #1;
      check("mid_rst_valid", res_valid, 0);
      check("mid_rst_count", count, 0);
      check("mid_rst_alu_i0", alu_i0, 0);
      check("mid_rst_alu_i1", alu_i1, 0);
      check("mid_rst_alu_sel", alu_select, 0);
      check("mid_rst_alu_sh", alu_shift_mag, 0);
      @(posedge clk);
      #3 rst = 1'b0;
      tick();
      check("mid_ready", cmd_ready, 1);
      for (int k = 0; k < 10; k++) begin
         tick();
         check("mid_no_stale", res_valid, 0);
      end
      check("mid_results", n_res - n0, 0);

      // Pointer wrap with random traffic and random backpressure.
      for (int r = 0; r < 3; r++) begin
         n0        = n_res;
         push_done = 1'b0;
         fork
            begin
               for (int k = 0; k < 2 * DEPTH + 1; k++) begin
                  repeat ($urandom_range(0, 2)) tick();
                  push(WIDTH'($urandom), WIDTH'($urandom), SEL_W'($urandom), SH_W'($urandom));
               end
               push_done = 1'b1;
            end
            begin
               while (!push_done) begin
                  res_ready = ($urandom_range(0, 2) != 0);
                  tick();
               end
            end
         join
         drain("wrap_drain");
         check("wrap_results", n_res - n0, 2 * DEPTH + 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
